// File: rtl/micro_sequencer_if.sv
// Decoded-instruction handshake between the instruction decoder and the micro-sequencer.
// valid/ready: a transfer happens on the rising edge where instr_valid & instr_ready; the sender holds opcode/address stable while valid is high.
interface micro_sequencer_if #(
    parameter int OPCODE_W = 6,
    parameter int DADDR_W  = 11
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] instr_opcode;
    logic [DADDR_W-1:0]  instr_address;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_address,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_address,
        output instr_ready
    );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: dispatches opcodes to microroutine start addresses and steps the
// micro-PC feeding an asynchronous microinstruction ROM; busy exposes the FSM state.
module micro_sequencer #(
    parameter int UPC_W    = 8,
    parameter int OPCODE_W = 6,
    parameter int DADDR_W  = 11
) (
    input  logic               clock,
    input  logic               reset,
    micro_sequencer_if.slave   instr,
    input  logic [1:0]         mseq_ctrl,
    input  logic [UPC_W-1:0]   jump_target,
    input  logic               zero_flag,
    input  logic               stall,
    output logic [UPC_W-1:0]   rom_address,
    output logic [DADDR_W-1:0] data_address_out,
    output logic               busy,
    output logic               seq_error
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CTRL_NEXT = 2'b00;
    localparam logic [1:0] CTRL_END  = 2'b01;
    localparam logic [1:0] CTRL_JUMP = 2'b10;
    localparam logic [1:0] CTRL_JZ   = 2'b11;

    state_t             state;
    logic [UPC_W-1:0]   dispatch_addr;
    logic [UPC_W-1:0]   incr_addr;
    logic               at_top;

    // Opcode occupies the upper bits of the micro-PC; each routine gets a fixed-size slot.
    assign dispatch_addr = UPC_W'(instr.instr_opcode) << (UPC_W - OPCODE_W);
    assign incr_addr     = rom_address + 1'b1;
    assign at_top        = &rom_address;

    assign busy              = (state == RUN);
    assign instr.instr_ready = (state == IDLE) ||
                               ((state == RUN) && (mseq_ctrl == CTRL_END) && !stall);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rom_address      <= '0;
            data_address_out <= '0;
            seq_error        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr.instr_valid) begin
                        rom_address      <= dispatch_addr;
                        data_address_out <= instr.instr_address;
                        state            <= RUN;
                    end else begin
                        rom_address <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        case (mseq_ctrl)
                            CTRL_END: begin
                                if (instr.instr_valid) begin
                                    rom_address      <= dispatch_addr;
                                    data_address_out <= instr.instr_address;
                                end else begin
                                    rom_address <= '0;
                                    state       <= IDLE;
                                end
                            end
                            CTRL_JUMP: rom_address <= jump_target;
                            CTRL_JZ: begin
                                if (zero_flag) begin
                                    rom_address <= jump_target;
                                end else if (at_top) begin
                                    seq_error   <= 1'b1;
                                    rom_address <= '0;
                                    state       <= IDLE;
                                end else begin
                                    rom_address <= incr_addr;
                                end
                            end
                            default: begin
                                // Falling off the end of the ROM is a microcode bug: park on the NOP word.
                                if (at_top) begin
                                    seq_error   <= 1'b1;
                                    rom_address <= '0;
                                    state       <= IDLE;
                                end else begin
                                    rom_address <= incr_addr;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state       <= IDLE;
                    rom_address <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed, table-driven bench for micro_sequencer with a small microcode ROM model.
module tb_micro_sequencer;

    localparam int UPC_W    = 8;
    localparam int OPCODE_W = 6;
    localparam int DADDR_W  = 11;

    logic               clock;
    logic               reset;
    logic [1:0]         mseq_ctrl;
    logic [UPC_W-1:0]   jump_target;
    logic               zero_flag;
    logic               stall;
    logic [UPC_W-1:0]   rom_address;
    logic [DADDR_W-1:0] data_address_out;
    logic               busy;
    logic               seq_error;

    logic [1:0]       rom_ctrl [256];
    logic [UPC_W-1:0] rom_tgt  [256];

    int checks   = 0;
    int failures = 0;

    micro_sequencer_if #(.OPCODE_W(OPCODE_W), .DADDR_W(DADDR_W)) instr_bus ();

    micro_sequencer #(.UPC_W(UPC_W), .OPCODE_W(OPCODE_W), .DADDR_W(DADDR_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .instr            (instr_bus.slave),
        .mseq_ctrl        (mseq_ctrl),
        .jump_target      (jump_target),
        .zero_flag        (zero_flag),
        .stall            (stall),
        .rom_address      (rom_address),
        .data_address_out (data_address_out),
        .busy             (busy),
        .seq_error        (seq_error)
    );

    // Combinational ROM: sequencing fields of the word at the current micro-PC.
    assign mseq_ctrl   = rom_ctrl[rom_address];
    assign jump_target = rom_tgt[rom_address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic               valid;
        logic [OPCODE_W-1:0] opcode;
        logic [DADDR_W-1:0] addr;
        logic               stl;
        logic               zero;
        logic               exp_ready;
        logic [UPC_W-1:0]   exp_rom;
        logic [DADDR_W-1:0] exp_daddr;
        logic               exp_busy;
        logic               exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [OPCODE_W-1:0] op, input logic [DADDR_W-1:0] a,
                       input logic s, input logic z, input logic er, input logic [UPC_W-1:0] erom,
                       input logic [DADDR_W-1:0] ed, input logic eb, input logic ee);
        vec_t t;
        t.valid = v; t.opcode = op; t.addr = a; t.stl = s; t.zero = z;
        t.exp_ready = er; t.exp_rom = erom; t.exp_daddr = ed; t.exp_busy = eb; t.exp_err = ee;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [OPCODE_W-1:0] op,
                         input logic [DADDR_W-1:0] a, input logic s, input logic z);
        instr_bus.instr_valid   = v;
        instr_bus.instr_opcode  = op;
        instr_bus.instr_address = a;
        stall     = s;
        zero_flag = z;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_ctrl[i] = 2'b01;
            rom_tgt[i]  = '0;
        end
        rom_ctrl[8'h14] = 2'b00; rom_ctrl[8'h15] = 2'b00; rom_ctrl[8'h16] = 2'b01;
        rom_ctrl[8'h08] = 2'b01;
        rom_ctrl[8'h20] = 2'b11; rom_tgt[8'h20] = 8'h30;
        rom_ctrl[8'h21] = 2'b01;
        rom_ctrl[8'h30] = 2'b10; rom_tgt[8'h30] = 8'h24;
        rom_ctrl[8'h24] = 2'b01;
        for (int i = 8'h10; i <= 8'h13; i++) rom_ctrl[i] = 2'b00;
        for (int i = 8'hFC; i <= 8'hFF; i++) rom_ctrl[i] = 2'b00;

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_rom",   -1, 32'(rom_address),      32'h0);
        check("reset_daddr", -1, 32'(data_address_out), 32'h0);
        check("reset_busy",  -1, 32'(busy),             32'h0);
        check("reset_err",   -1, 32'(seq_error),        32'h0);
        check("reset_ready", -1, 32'(instr_bus.instr_ready), 32'h1);

        //   v    op     addr     stl  z    rdy  rom    daddr    busy err
        // single instruction 0x05 -> 0x14..0x16
        add(1, 6'h05, 11'h3A7, 0, 0, 1, 8'h14, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h15, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h16, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h3A7, 0, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h3A7, 0, 0);
        // stall at 0x15 for 3 cycles, then back-to-back dispatch at END
        add(1, 6'h05, 11'h3A7, 0, 0, 1, 8'h14, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h15, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 1, 0, 0, 8'h15, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 1, 0, 0, 8'h15, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 1, 0, 0, 8'h15, 11'h3A7, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h16, 11'h3A7, 1, 0);
        add(1, 6'h02, 11'h001, 0, 0, 1, 8'h08, 11'h001, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h001, 0, 0);
        // stall ignored in IDLE; JZ taken, JUMP
        add(1, 6'h08, 11'h055, 1, 0, 1, 8'h20, 11'h055, 1, 0);
        add(0, 6'h00, 11'h000, 0, 1, 0, 8'h30, 11'h055, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h24, 11'h055, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h055, 0, 0);
        // JZ not taken
        add(1, 6'h08, 11'h066, 0, 0, 1, 8'h20, 11'h066, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h21, 11'h066, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h066, 0, 0);
        // stalled END must not accept a waiting instruction
        add(1, 6'h05, 11'h100, 0, 0, 1, 8'h14, 11'h100, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h15, 11'h100, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h16, 11'h100, 1, 0);
        add(1, 6'h02, 11'h001, 1, 0, 0, 8'h16, 11'h100, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h100, 0, 0);
        // overflow: NEXT at 0xFF
        add(1, 6'h3F, 11'h7FF, 0, 0, 1, 8'hFC, 11'h7FF, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'hFD, 11'h7FF, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'hFE, 11'h7FF, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'hFF, 11'h7FF, 1, 0);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h00, 11'h7FF, 0, 1);
        // sticky error across a later instruction
        add(1, 6'h05, 11'h2AA, 0, 0, 1, 8'h14, 11'h2AA, 1, 1);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h15, 11'h2AA, 1, 1);
        add(0, 6'h00, 11'h000, 0, 0, 0, 8'h16, 11'h2AA, 1, 1);
        add(0, 6'h00, 11'h000, 0, 0, 1, 8'h00, 11'h2AA, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].valid, vecs[i].opcode, vecs[i].addr, vecs[i].stl, vecs[i].zero);
            #1;
            check("ready", i, 32'(instr_bus.instr_ready), 32'(vecs[i].exp_ready));
            @(posedge clock);
            #1;
            check("rom_address", i, 32'(rom_address),      32'(vecs[i].exp_rom));
            check("data_addr",   i, 32'(data_address_out), 32'(vecs[i].exp_daddr));
            check("busy",        i, 32'(busy),             32'(vecs[i].exp_busy));
            check("seq_error",   i, 32'(seq_error),        32'(vecs[i].exp_err));
        end

        // Asynchronous reset mid-routine at 0x13, with seq_error still set.
        @(negedge clock);
        drive(1'b1, 6'h04, 11'h123, 1'b0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("pre_reset_rom",  100, 32'(rom_address), 32'h13);
        check("pre_reset_err",  100, 32'(seq_error),   32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rom",   101, 32'(rom_address),      32'h0);
        check("async_rst_daddr", 101, 32'(data_address_out), 32'h0);
        check("async_rst_busy",  101, 32'(busy),             32'h0);
        check("async_rst_err",   101, 32'(seq_error),        32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_rom",   102, 32'(rom_address), 32'h0);
        check("post_rst_ready", 102, 32'(instr_bus.instr_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
